// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    localparam int IRQ_MAX   = 16;
    localparam int IRQ_IDX_W = $clog2(IRQ_MAX);

    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SVC,
        ACK
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the candidate interrupt vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_IRQ = 16
) (
    input  logic [N_IRQ-1:0]     vec,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = |vec;
        idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Single-level interrupt controller in front of the core's irq_req/irq_ret pair.
// Optional macro IRQ_EDGE_EN switches inputs from level- to rising-edge-sensitive.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_lines_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic             stall_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             irq_busy_o
);

    irq_state_t           state;
    logic [IRQ_IDX_W-1:0] sel_idx;
    logic [N_IRQ-1:0]     sel_onehot;
    logic [N_IRQ-1:0]     candidate;
    logic                 cand_valid;
    logic [IRQ_IDX_W-1:0] cand_idx;

    // Decode the committed source into its one-hot line position.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            sel_onehot[i] = (sel_idx == IRQ_IDX_W'(i));
        end
    end

`ifdef IRQ_EDGE_EN
    logic [N_IRQ-1:0] line_q;
    logic [N_IRQ-1:0] pending;

    // Capture rising edges; a fresh edge in the ACK cycle beats the clear.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            line_q  <= '0;
            pending <= '0;
        end else begin
            line_q  <= irq_lines_i;
            pending <= (pending & ~((state == ACK) ? sel_onehot : '0))
                     | (irq_lines_i & ~line_q);
        end
    end

    assign candidate = pending & irq_mask_i;
`else
    assign candidate = irq_lines_i & irq_mask_i;
`endif

    irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .vec   (candidate),
        .valid (cand_valid),
        .idx   (cand_idx)
    );

    // Request/service/acknowledge sequencing with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            sel_idx     <= '0;
            irq_req_o   <= 1'b0;
            irq_cause_o <= '0;
            irq_ack_o   <= '0;
            irq_busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    irq_ack_o <= '0;
                    if (cand_valid) begin
                        state       <= REQ;
                        sel_idx     <= cand_idx;
                        irq_cause_o <= IRQ_CAUSE_BASE
                                     + {{(32 - IRQ_IDX_W){1'b0}}, cand_idx};
                        irq_req_o   <= 1'b1;
                        irq_busy_o  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!stall_i) begin
                        state     <= SVC;
                        irq_req_o <= 1'b0;
                    end
                end
                SVC: begin
                    if (irq_ret_i) begin
                        state     <= ACK;
                        irq_ack_o <= sel_onehot;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    irq_ack_o  <= '0;
                    irq_busy_o <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    irq_req_o  <= 1'b0;
                    irq_ack_o  <= '0;
                    irq_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sits directly upstream of the processor core's `irq_req_i`/`irq_ret_o` pair. It collects up to 16 peripheral interrupt lines, masks them with the core's enable vector, and selects the highest-priority source (lowest index). It raises a held request to the core, reports the trap cause, and acknowledges the serviced peripheral once the core returns from the handler. One interrupt is in service at a time; there is no nesting.

## Interface
- `N_IRQ`, default 16: number of interrupt lines; legal range 1..16.
- `clk_i  in  1`: clock; all logic is rising-edge.
- `rst_i  in  1`: reset, synchronous, active-low.
- `irq_lines_i  in  N_IRQ`: peripheral interrupt lines, synchronous to `clk_i`.
- `irq_mask_i  in  N_IRQ`: per-line enable from the core's mie CSR; 1 = enabled.
- `stall_i  in  1`: core stall; the core only accepts `irq_req_o` in a cycle with `stall_i` = 0.
- `irq_ret_i  in  1`: one-cycle pulse from the core on mret.
- `irq_req_o  out  1`: interrupt request to the core.
- `irq_cause_o  out  32`: mcause value for the selected source.
- `irq_ack_o  out  N_IRQ`: one-hot, one-cycle acknowledge to the serviced peripheral.
- `irq_busy_o  out  1`: high while a request or service is outstanding.

## Operation
- FSM states and transitions:
  - IDLE → REQ: when any candidate is set. Latch `sel_idx`, the lowest set index of the candidate vector.
  - REQ → SVC: at the edge where `stall_i` = 0.
  - SVC → ACK: on `irq_ret_i` = 1.
  - ACK → IDLE: unconditionally after one cycle.
- Candidate vector:
  - With the macro: `pending & irq_mask_i`.
  - Without the macro: `irq_lines_i & irq_mask_i`.
- Outputs per state:
  - `irq_req_o` = 1 exactly in REQ.
  - `irq_busy_o` = 1 in REQ, SVC and ACK.
  - `irq_ack_o` = one-hot(`sel_idx`) only in ACK, zero otherwise.
- `irq_cause_o` = 32'h8000_0010 + `sel_idx`. It is valid from REQ through ACK and holds its last value in IDLE.
- Mask or line changes after the IDLE → REQ transition do not cancel or retarget the request; the committed source is serviced.
- Requests arriving in REQ, SVC or ACK wait. They are re-evaluated in IDLE, in priority order.
- `irq_ret_i` outside SVC is ignored.
- Level mode: a peripheral must drop its line no later than the cycle after its `irq_ack_o` pulse. A line still high in IDLE re-triggers.
- Reset:
  - Takes effect mid-operation from any state to IDLE.
  - All outputs go to 0; `irq_cause_o` = 0.
  - The pending and line history registers clear.

## Timing
- Level mode: line rises in cycle t → `irq_req_o` = 1 in cycle t+1.
- Edge mode: line rises in cycle t → pending set at end of t → `irq_req_o` = 1 in cycle t+2.
- With `stall_i` = 0, `irq_req_o` is a one-cycle pulse. With `stall_i` held high for k cycles, `irq_req_o` stays high for k+1 cycles.
- `irq_ret_i` in cycle s → `irq_ack_o` pulse in cycle s+1 → IDLE at s+2. A new request can appear at s+3 at the earliest.
- Minimum turnaround between back-to-back services: 2 idle-side cycles after the ack.

## Configuration
- `IRQ_EDGE_EN` defined: rising-edge-sensitive inputs.
  - `line_q` register; `pending[i]` is set on `irq_lines_i[i] & ~line_q[i]`.
  - `pending[sel_idx]` is cleared in ACK.
  - A new edge on the same line in the same cycle as the clear leaves it set (set wins).
  - Masked edges still set `pending` and fire once unmasked.
- `IRQ_EDGE_EN` undefined: level-sensitive; no `pending` or `line_q` registers.

## Structure
- Package `irq_pkg` holds:
  - the FSM state enum (IDLE, REQ, SVC, ACK);
  - `IRQ_CAUSE_BASE` = 32'h8000_0010;
  - `IRQ_MAX` = 16.
- Sub-module `irq_prio_enc`: combinational lowest-index priority encoder. It outputs `valid` and a 4-bit index from an `N_IRQ`-bit vector.

## Test plan
- Level, line 3 high, mask all ones, `stall_i` = 0 → `irq_req_o` one cycle, `irq_cause_o` = 32'h8000_0013; `irq_ret_i` → `irq_ack_o` = 16'h0008 next cycle.
- Lines 2 and 5 high together → line 2 serviced first (cause …_0012). After its ack and line drop, line 5 is serviced (cause …_0015).
- `stall_i` held high for 4 cycles during REQ → `irq_req_o` high 5 cycles, then SVC; `irq_busy_o` high throughout.
- Line 7 high with `irq_mask_i[7]` = 0 → no request. Set the mask bit → request within 1 cycle (level mode).
- `IRQ_EDGE_EN`:
  - a 1-cycle pulse on line 1 → request at t+2, cause …_0011;
  - a second edge on line 1 in the ACK cycle → pending stays set, re-request after IDLE.
- `rst_i` = 0 during SVC → next cycle all outputs 0, state IDLE. A stray `irq_ret_i` afterwards produces no ack.
